// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, E0/F0 prefix stripping, timeout abort.
// Strobes are registered and appear the cycle after the stop-bit fall; there is no backpressure.
module ps2_rx_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_code_o,
  output logic       code_valid_o,
  output logic       break_o,
  output logic       extended_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall, timeout;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          ext, ext_n, brk, brk_n;
  logic [7:0]    code_n;
  logic          brk_o_n, ext_o_n, vld_n, perr_n, ferr_n;

  // Synchronizers and clock filter idle high so reset never looks like an edge.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk_i;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data_i;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + {{(FW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fall    = filt_prev & ~filt_clk;
  assign timeout = (state != IDLE) && !fall && (tcnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par          <= 1'b0;
      tcnt         <= '0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      scan_code_o  <= '0;
      break_o      <= 1'b0;
      extended_o   <= 1'b0;
      code_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      par          <= par_n;
      tcnt         <= tcnt_n;
      ext          <= ext_n;
      brk          <= brk_n;
      scan_code_o  <= code_n;
      break_o      <= brk_o_n;
      extended_o   <= ext_o_n;
      code_valid_o <= vld_n;
      parity_err_o <= perr_n;
      frame_err_o  <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_n     = par;
    ext_n     = ext;
    brk_n     = brk;
    code_n    = scan_code_o;
    brk_o_n   = break_o;
    ext_o_n   = extended_o;
    vld_n     = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    if (state == IDLE || fall) tcnt_n = '0;
    else                       tcnt_n = tcnt + {{(TW-1){1'b0}}, 1'b1};

    case (state)
      IDLE: begin
        // A fall with data high is a stray edge, not a start bit.
        if (fall && !dat_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {dat_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_n   = dat_s2;
          state_n = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (!dat_s2) begin
            ferr_n = 1'b1;
            ext_n  = 1'b0;
            brk_n  = 1'b0;
          end else if (~^{shreg, par}) begin
            perr_n = 1'b1;
            ext_n  = 1'b0;
            brk_n  = 1'b0;
          end else if (shreg == 8'hE0) begin
            ext_n = 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_n = 1'b1;
          end else begin
            code_n  = shreg;
            brk_o_n = brk;
            ext_o_n = ext;
            vld_n   = 1'b1;
            ext_n   = 1'b0;
            brk_n   = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (timeout) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed and randomized PS/2 frames against a byte-level reference model of the decoder.
module tb_ps2_rx_decoder;

  localparam int FILT = 8;
  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       ps2_clk_i, ps2_data_i;
  logic [7:0] scan_code_o;
  logic       code_valid_o, break_o, extended_o, parity_err_o, frame_err_o;

  ps2_rx_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RSTn(RSTn), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .scan_code_o(scan_code_o), .code_valid_o(code_valid_o), .break_o(break_o),
    .extended_o(extended_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o)
  );

  always #10 CLK = ~CLK;

  // kind: 1 code, 2 parity error, 3 frame error, 0 more than one strobe at once
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t dut_q[$];
  ev_t exp_q[$];
  int  dut_cyc[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  logic       m_ext, m_brk;
  logic [7:0] m_code;
  logic       m_cbrk, m_cext;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    int n;
    n = int'(code_valid_o === 1'b1) + int'(parity_err_o === 1'b1) + int'(frame_err_o === 1'b1);
    if (n > 1) begin
      dut_q.push_back('{2'd0, 8'h00, 1'b0, 1'b0});
      dut_cyc.push_back(cyc);
    end else if (code_valid_o === 1'b1) begin
      dut_q.push_back('{2'd1, scan_code_o, break_o, extended_o});
      dut_cyc.push_back(cyc);
    end else if (parity_err_o === 1'b1) begin
      dut_q.push_back('{2'd2, 8'h00, 1'b0, 1'b0});
      dut_cyc.push_back(cyc);
    end else if (frame_err_o === 1'b1) begin
      dut_q.push_back('{2'd3, 8'h00, 1'b0, 1'b0});
      dut_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (stop_bad) begin
      exp_q.push_back('{2'd3, 8'h00, 1'b0, 1'b0});
      m_ext = 0; m_brk = 0;
    end else if (par_bad) begin
      exp_q.push_back('{2'd2, 8'h00, 1'b0, 1'b0});
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back('{2'd1, b, m_brk, m_ext});
      m_code = b; m_cbrk = m_brk; m_cext = m_ext;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Device-side frame: data changes while the clock is high, the receiver samples on falls.
  task automatic send_bits(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                           input int nbits, output int t_fall);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    t_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = bits[i];
      repeat (HALF) @(posedge CLK);
      ps2_clk_i = 1'b0;
      t_fall = cyc;
      repeat (HALF) @(posedge CLK);
      ps2_clk_i = 1'b1;
    end
    repeat (HALF) @(posedge CLK);
    ps2_data_i = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    int t;
    send_bits(b, par_bad, stop_bad, 11, t);
    model_frame(b, par_bad, stop_bad);
  endtask

  task automatic compare_events(input string tag);
    int n;
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    check({tag, "_count"}, dut_q.size(), exp_q.size());
    n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, "_event"}, 32'(dut_q[i]), 32'(exp_q[i]));
    check({tag, "_hold"}, {scan_code_o, break_o, extended_o}, {m_code, m_cbrk, m_cext});
    dut_q.delete();
    exp_q.delete();
    dut_cyc.delete();
  endtask

  initial begin
    int t_fall, d, waited;
    logic [7:0] b;
    int r, e;

    RSTn = 1'b0; ps2_clk_i = 1'b1; ps2_data_i = 1'b1;
    m_ext = 0; m_brk = 0; m_code = 0; m_cbrk = 0; m_cext = 0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {scan_code_o, break_o, extended_o, code_valid_o, parity_err_o, frame_err_o}, 0);
    @(posedge CLK);
    RSTn = 1'b1;
    repeat (10) @(posedge CLK);
    dut_q.delete(); dut_cyc.delete();

    send(8'h1C, 0, 0);
    compare_events("make_1c");

    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    send(8'h1C, 0, 0);
    compare_events("break_1c");

    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);
    compare_events("ext_break_75");

    send(8'h1C, 1, 0);
    compare_events("parity_err");
    send(8'h1C, 0, 1);
    compare_events("stop_err");

    // Prefix followed by an error must not leak into the next code.
    send(8'hF0, 0, 0);
    send(8'h33, 1, 0);
    send(8'h33, 0, 0);
    compare_events("err_clears_flags");

    // Short low pulse with data low: would look like a start bit if it got through.
    ps2_data_i = 1'b0;
    @(posedge CLK); ps2_clk_i = 1'b0;
    repeat (3) @(posedge CLK); ps2_clk_i = 1'b1;
    repeat (5) @(posedge CLK); ps2_data_i = 1'b1;
    repeat (TO + 50) @(posedge CLK);
    compare_events("glitch_none");
    send(8'h4B, 0, 0);
    compare_events("after_glitch");

    send(8'hE0, 0, 0);
    send_bits(8'hA5, 0, 0, 5, t_fall);
    waited = 0;
    while (dut_q.size() == 0 && waited < TO + 200) begin
      @(posedge CLK);
      waited++;
    end
    @(negedge CLK);
    check("timeout_seen", dut_q.size() > 0, 1);
    d = (dut_cyc.size() > 0) ? dut_cyc[0] - t_fall : 0;
    check("timeout_latency", (d >= TO && d <= TO + 20), 1);
    exp_q.push_back('{2'd3, 8'h00, 1'b0, 1'b0});
    m_ext = 0; m_brk = 0;
    compare_events("timeout");
    send(8'h29, 0, 0);
    compare_events("after_timeout_29");

    send(8'hF0, 0, 0);
    send_bits(8'h5A, 0, 0, 5, t_fall);
    @(posedge CLK); RSTn = 1'b0;
    @(posedge CLK); RSTn = 1'b1;
    m_ext = 0; m_brk = 0; m_code = 0; m_cbrk = 0; m_cext = 0;
    @(negedge CLK);
    check("midframe_reset_outputs", {scan_code_o, break_o, extended_o, code_valid_o, parity_err_o, frame_err_o}, 0);
    repeat (TO + 100) @(posedge CLK);
    compare_events("midframe_reset_none");
    send(8'h5A, 0, 0);
    compare_events("after_reset_5a");

    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      e = $urandom_range(0, 9);
      send(b, e == 0, e == 1);
      compare_events("random");
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
